// File: rtl/nco_phase_gen.sv
// nco_phase_gen: phase-accumulator NCO feeding the CORDIC arg input.
// Supports phase offset, linear chirp, and fixed-length burst or
// continuous tone.
//
// state | meaning
// IDLE  | accepting config, waiting for start
// RUN   | emitting one phase word per enabled clock
module nco_phase_gen #(
  parameter int ACC_WIDTH = 32,
  parameter int ARG_WIDTH = 16,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ACC_WIDTH-1:0] cfg_fcw,
  input  logic [ACC_WIDTH-1:0] cfg_step,
  input  logic [ARG_WIDTH-1:0] cfg_phase_ofs,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 en,
  output logic [ARG_WIDTH-1:0] arg,
  output logic                 arg_valid,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] fcw;
  logic [ACC_WIDTH-1:0] step;
  logic [ARG_WIDTH-1:0] ofs;
  logic [LEN_WIDTH-1:0] len;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] fcw_cur;
  logic [LEN_WIDTH-1:0] cnt;
  // Set on the edge that emits the final burst sample; done follows it by
  // one cycle so it lands after the last valid sample, never alongside it.
  logic                 last_smp;

  assign busy      = (state == RUN);
  assign cfg_ready = (state == IDLE);

  // Sequencer, config capture and phase datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      fcw       <= '0;
      step      <= '0;
      ofs       <= '0;
      len       <= '0;
      acc       <= '0;
      fcw_cur   <= '0;
      cnt       <= '0;
      arg       <= '0;
      arg_valid <= 1'b0;
      done      <= 1'b0;
      last_smp  <= 1'b0;
    end else begin
      arg_valid <= 1'b0;
      done      <= last_smp;
      last_smp  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            // Config takes priority over a coincident start.
            fcw  <= cfg_fcw;
            step <= cfg_step;
            ofs  <= cfg_phase_ofs;
            len  <= cfg_len;
          end else if (start && !stop) begin
            state   <= RUN;
            acc     <= '0;
            fcw_cur <= fcw;
            cnt     <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (en) begin
            arg       <= acc[ACC_WIDTH-1 -: ARG_WIDTH] + ofs;
            arg_valid <= 1'b1;
            acc       <= acc + fcw_cur;
            fcw_cur   <= fcw_cur + step;
            cnt       <= cnt + LEN_WIDTH'(1);
            // len == 0 is continuous mode: cnt wraps and never terminates.
            if ((len != '0) && (cnt == len - LEN_WIDTH'(1))) begin
              state    <= IDLE;
              last_smp <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Scoreboard bench for nco_phase_gen: stimulus pushes expected arg words,
// a negedge monitor pops and compares each valid sample.
module tb_nco_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_fcw;
  logic [31:0] cfg_step;
  logic [15:0] cfg_phase_ofs;
  logic [15:0] cfg_len;
  logic        start;
  logic        stop;
  logic        en;
  logic [15:0] arg;
  logic        arg_valid;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  nco_phase_gen #(.ACC_WIDTH(32), .ARG_WIDTH(16), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_fcw(cfg_fcw), .cfg_step(cfg_step),
    .cfg_phase_ofs(cfg_phase_ofs), .cfg_len(cfg_len),
    .start(start), .stop(stop), .en(en),
    .arg(arg), .arg_valid(arg_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_cfg(input logic [31:0] f, input logic [31:0] s,
                        input logic [15:0] o, input logic [15:0] l);
    cfg_valid     = 1'b1;
    cfg_fcw       = f;
    cfg_step      = s;
    cfg_phase_ofs = o;
    cfg_len       = l;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Start a burst with en held high and wait for done (bounded).
  task automatic run_burst(input string name);
    int  n;
    bit  seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_busy_start"}, 32'(busy), 32'd1);
    en   = 1'b1;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 60) begin
      tick();
      n++;
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({name, "_valid_at_done"}, 32'(arg_valid), 32'd0);
    chk({name, "_q_drained"}, 32'(exp_q.size()), 32'd0);
    tick();
    chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
    en = 1'b0;
  endtask

  // Monitor: compare every valid sample against the scoreboard.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (arg_valid && done) begin
        checks++;
        errors++;
        $display("FAIL valid_and_done both high arg %h", arg);
      end
      if (arg_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL arg_unexpected got %h expected none", arg);
        end else begin
          e = exp_q.pop_front();
          if (arg !== e) begin
            errors++;
            $display("FAIL arg_sample got %h expected %h", arg, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_fcw = '0; cfg_step = '0;
    cfg_phase_ofs = '0; cfg_len = '0; start = 1'b0; stop = 1'b0; en = 1'b0;
    tick();
    tick();
    chk("rst_arg", 32'(arg), 32'h0);
    chk("rst_valid", 32'(arg_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Quarter-turn steps, 8-sample burst.
    do_cfg(32'h4000_0000, 32'h0, 16'h0, 16'd8);
    foreach (exp_q[i]) ;
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(i % 4) << 14);
    run_burst("quarter");

    // Offset wrap.
    do_cfg(32'h6000_0000, 32'h0, 16'hE000, 16'd3);
    exp_q.push_back(16'hE000); exp_q.push_back(16'h4000); exp_q.push_back(16'hA000);
    run_burst("ofs_wrap");

    // Linear chirp.
    do_cfg(32'h0001_0000, 32'h0001_0000, 16'h0, 16'd4);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0003); exp_q.push_back(16'h0006);
    run_burst("chirp");

    // Continuous tone with enable gaps and stop.
    do_cfg(32'h1000_0000, 32'h0, 16'h0, 16'd0);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h1000);
    start = 1'b1; tick(); start = 1'b0;
    en = 1'b1; tick(); tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_arg_hold", 32'(arg), 32'h1000);
      chk("gap_valid", 32'(arg_valid), 32'd0);
    end
    exp_q.push_back(16'h2000);
    en = 1'b1; tick(); en = 1'b0;
    cfg_valid = 1'b1; cfg_fcw = 32'h2000_0000; cfg_len = 16'd5;
    chk("busy_cfg_ready", 32'(cfg_ready), 32'd0);
    tick();
    cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("start_while_busy", 32'(busy), 32'd1);
    stop = 1'b1; en = 1'b1; tick(); stop = 1'b0; en = 1'b0;
    chk("stop_valid", 32'(arg_valid), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    tick();
    chk("stop_done_later", 32'(done), 32'd0);
    chk("cont_q_drained", 32'(exp_q.size()), 32'd0);

    // Old config retained: still continuous at 0x10000000.
    exp_q.push_back(16'h0000); exp_q.push_back(16'h1000); exp_q.push_back(16'h2000);
    start = 1'b1; tick(); start = 1'b0;
    en = 1'b1; tick(); tick(); tick(); en = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    chk("oldcfg_q_drained", 32'(exp_q.size()), 32'd0);

    // Start together with stop in IDLE: stop wins.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", 32'(busy), 32'd0);

    // Config with start in IDLE: captured, stays IDLE.
    cfg_valid = 1'b1; cfg_fcw = 32'h4000_0000; cfg_step = '0;
    cfg_phase_ofs = '0; cfg_len = 16'd2; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("cfg_start_busy", 32'(busy), 32'd0);
    chk("cfg_start_ready", 32'(cfg_ready), 32'd1);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h4000);
    run_burst("newcfg");

    // Reset mid-burst clears config.
    do_cfg(32'h4000_0000, 32'h0, 16'h0, 16'd8);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h4000); exp_q.push_back(16'h8000);
    start = 1'b1; tick(); start = 1'b0;
    en = 1'b1; tick(); tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mid_rst_arg", 32'(arg), 32'h0);
    chk("mid_rst_valid", 32'(arg_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ready", 32'(cfg_ready), 32'd1);
    chk("mid_rst_q", 32'(exp_q.size()), 32'd0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h0000);
    start = 1'b1; tick(); start = 1'b0;
    en = 1'b1; tick(); tick(); tick(); tick(); en = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    chk("cleared_busy", 32'(busy), 32'd0);
    chk("cleared_q_drained", 32'(exp_q.size()), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
